mux16_rr_sched: RTL and testbench

Round-robin scheduler that shares the 16:1 single-bit mux (`mux16_1`) among 16 requesters. It arbitrates pending requests, drives the mux select and a one-hot grant vector, and holds each grant for a programmable number of cycles or until the requester releases. It sits directly in front of `mux16_1`; its `sel` output connects to the mux select, and its `gnt` output goes back to the requesting sources.

---
 rtl/mux16_rr_sched.sv | 125 ++++++++++++
 tb/tb_mux16_rr_sched.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler in front of a 16:1 single-bit mux. Arbitrates the
// request vector, drives the mux select and a one-hot grant, and holds each
// grant for hold_len+1 cycles or until the grantee drops its request.
module mux16_rr_sched #(
  parameter int unsigned NREQ = 16,
  parameter int unsigned SELW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [3:0]      hold_len,
  output logic [SELW-1:0] sel,
  output logic [NREQ-1:0] gnt,
  output logic            valid,
  output logic            done
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   last_q, last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [SELW-1:0]   win;
  logic [SELW-1:0]   cand;
  logic              found;
  logic              any_req;

  assign any_req = |req;

  // Round-robin search starting just after the last grantee; the previous
  // grantee is scanned last. Index arithmetic wraps because NREQ == 2**SELW.
  always_comb begin
    win   = last_q;
    cand  = last_q;
    found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = last_q + SELW'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StBusy;
          sel_d   = win;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
          valid_d = 1'b1;
          cnt_d   = hold_len;
          last_d  = win;
        end
      end
      StBusy: begin
        if (req[sel_q] && (cnt_q != 4'd0)) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Grant ends here; hand over without a gap if anyone is waiting.
          done_d = 1'b1;
          if (any_req) begin
            sel_d   = win;
            gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
            valid_d = 1'b1;
            cnt_d   = hold_len;
            last_d  = win;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; last resets to the
  // top index so the first search after reset begins at index 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= '1;
      cnt_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign sel   = sel_q;
  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed bench for mux16_rr_sched: reset, single requester, full rotation,
// fairness ordering, early release and reset mid-grant.
module tb_mux16_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic [3:0]  hold_len;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        valid;
  logic        done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mux16_rr_sched #(.NREQ(16), .SELW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .hold_len (hold_len),
    .sel      (sel),
    .gnt      (gnt),
    .valid    (valid),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_sel, input logic [15:0] e_gnt,
                            input logic e_valid, input logic e_done);
    check({tag, ".sel"},   32'(sel),   32'(e_sel));
    check({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
    check({tag, ".valid"}, 32'(valid), 32'(e_valid));
    check({tag, ".done"},  32'(done),  32'(e_done));
  endtask

  // Per-cycle invariants: gnt zero or one-hot, matches sel, valid mirrors it.
  always @(negedge clk) begin
    if (chk_en) begin
      check("inv_onehot", 32'($onehot0(gnt)), 32'd1);
      check("inv_valid", 32'(valid), 32'(|gnt));
      if (gnt != 16'h0) check("inv_gntsel", 32'(gnt), 32'(16'h1 << sel));
    end
  end

  initial begin
    rst_n    = 1'b0;
    req      = 16'hFFFF;
    hold_len = 4'd0;

    // Reset held for 3 cycles with every request asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_en = 1'b1;
      expect_out("rst", 4'd0, 16'h0000, 1'b0, 1'b0);
    end
    rst_n = 1'b1;

    // Full rotation with hold_len=0: first grant to 0, then 1..15, 0.
    tick();
    expect_out("rot0", 4'd0, 16'h0001, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      expect_out($sformatf("rot%0d", i), 4'(i % 16), 16'h1 << (i % 16), 1'b1, 1'b1);
    end
    req = 16'h0000;
    tick();
    expect_out("rot_idle", 4'd0, 16'h0000, 1'b0, 1'b1);
    tick();
    expect_out("rot_idle2", 4'd0, 16'h0000, 1'b0, 1'b0);

    // Single requester 5, hold_len=3: four grant cycles then re-grant.
    req      = 16'h0020;
    hold_len = 4'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("single%0d", i), 4'd5, 16'h0020, 1'b1, 1'b0);
    end
    hold_len = 4'd9;  // must not affect the re-grant's length? it is sampled at re-grant
    hold_len = 4'd3;
    tick();
    expect_out("single_regrant", 4'd5, 16'h0020, 1'b1, 1'b1);
    req = 16'h0000;
    tick();
    expect_out("single_end", 4'd5, 16'h0000, 1'b0, 1'b1);
    tick();
    expect_out("single_idle", 4'd5, 16'h0000, 1'b0, 1'b0);

    // Fairness: grant 9 first, then requests 2, 9, 12 -> 12, 2, 9, 12.
    req      = 16'h0200;
    hold_len = 4'd0;
    tick();
    expect_out("fair_seed", 4'd9, 16'h0200, 1'b1, 1'b0);
    req = 16'h1204;
    tick();
    expect_out("fair12", 4'd12, 16'h1000, 1'b1, 1'b1);
    tick();
    expect_out("fair2", 4'd2, 16'h0004, 1'b1, 1'b1);
    tick();
    expect_out("fair9", 4'd9, 16'h0200, 1'b1, 1'b1);
    tick();
    expect_out("fair12b", 4'd12, 16'h1000, 1'b1, 1'b1);

    // Early release: requester 7, hold_len=15, dropped on the 3rd grant cycle.
    req      = 16'h0080;
    hold_len = 4'd15;
    tick();
    expect_out("early1", 4'd7, 16'h0080, 1'b1, 1'b1);
    tick();
    expect_out("early2", 4'd7, 16'h0080, 1'b1, 1'b0);
    tick();
    expect_out("early3", 4'd7, 16'h0080, 1'b1, 1'b0);
    req = 16'h0000;
    tick();
    expect_out("early_rel", 4'd7, 16'h0000, 1'b0, 1'b1);
    tick();
    expect_out("early_idle", 4'd7, 16'h0000, 1'b0, 1'b0);

    // Reset during a long grant: dropped without a done pulse.
    req      = 16'h0008;
    hold_len = 4'd10;
    tick();
    expect_out("mid_g1", 4'd3, 16'h0008, 1'b1, 1'b0);
    tick();
    expect_out("mid_g2", 4'd3, 16'h0008, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    expect_out("mid_rst", 4'd0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 16'h0009;
    tick();
    expect_out("mid_after", 4'd0, 16'h0001, 1'b1, 1'b0);
    tick();
    expect_out("mid_after2", 4'd0, 16'h0001, 1'b1, 1'b0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
